// File: rtl/instr_fetch_assembler.sv
// Halfword instruction fetch: reads 1-3 halfwords per instruction, assembles {hw0, hw1, hw2}
// and holds it for the decoder under valid/ready, with redirect from branch resolution.
module instr_fetch_assembler #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [47:0] instr,
  output logic [1:0]  instr_len,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch0,
    StFetch1,
    StFetch2,
    StHold
  } state_e;

  localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'd1;

  state_e      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_instr_valid;
  logic [47:0] r_instr;
  logic [1:0]  r_instr_len;
  logic [31:0] r_instr_pc;

  logic [1:0]  w_hw0_len;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_next_pc;

  // Group field of hw0 selects the instruction length in halfwords.
  always_comb begin
    w_hw0_len = 2'd2;
    case (mem_rdata[15:14])
      2'd0:    w_hw0_len = 2'd1;
      2'd3:    w_hw0_len = 2'd3;
      default: w_hw0_len = 2'd2;
    endcase
  end

  assign w_redirect_pc = redirect_pc & ~32'd1;
  assign w_next_pc     = r_fetch_pc + {29'd0, r_instr_len, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_fetch_pc    <= ResetPcAligned;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_instr       <= 48'd0;
      r_instr_len   <= 2'd0;
      r_instr_pc    <= 32'd0;
    end else if (redirect_valid) begin
      // Drops partial work and same-cycle ack data; a same-cycle handshake is simply consumed.
      r_state       <= StFetch0;
      r_fetch_pc    <= w_redirect_pc;
      r_mem_req     <= 1'b1;
      r_mem_addr    <= w_redirect_pc;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state    <= StFetch0;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_fetch_pc;
        end
        StFetch0: begin
          if (mem_ack) begin
            r_instr     <= {mem_rdata, 32'd0};
            r_instr_len <= w_hw0_len;
            r_instr_pc  <= r_fetch_pc;
            if (w_hw0_len == 2'd1) begin
              r_state       <= StHold;
              r_mem_req     <= 1'b0;
              r_instr_valid <= 1'b1;
            end else begin
              r_state    <= StFetch1;
              r_mem_addr <= r_fetch_pc + 32'd2;
            end
          end
        end
        StFetch1: begin
          if (mem_ack) begin
            r_instr[31:16] <= mem_rdata;
            if (r_instr_len == 2'd2) begin
              r_state       <= StHold;
              r_mem_req     <= 1'b0;
              r_instr_valid <= 1'b1;
            end else begin
              r_state    <= StFetch2;
              r_mem_addr <= r_fetch_pc + 32'd4;
            end
          end
        end
        StFetch2: begin
          if (mem_ack) begin
            r_instr[15:0] <= mem_rdata;
            r_state       <= StHold;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        StHold: begin
          if (instr_ready) begin
            r_state       <= StFetch0;
            r_fetch_pc    <= w_next_pc;
            r_mem_req     <= 1'b1;
            r_mem_addr    <= w_next_pc;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_len   = r_instr_len;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Bench for instr_fetch_assembler: directed scenarios, randomized traffic against a
// transaction-level model, and a second instance exercising address wrap-around.
module tb_instr_fetch_assembler;

  logic        clk = 1'b0;
  logic        rst, mem_ack, instr_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] mem_rdata;
  logic        mem_req, instr_valid;
  logic [31:0] mem_addr, instr_pc;
  logic [47:0] instr;
  logic [1:0]  instr_len;

  logic        rst_b, ack_b, ready_b, rv_b;
  logic [31:0] rpc_b;
  logic [15:0] rdata_b;
  logic        req_b, valid_b;
  logic [31:0] addr_b, pc_b;
  logic [47:0] instr_b;
  logic [1:0]  len_b;

  logic [15:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;

  instr_fetch_assembler #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_len(instr_len), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instr_fetch_assembler #(.RESET_PC(32'hFFFF_FFFF)) u_dut_b (
    .clk(clk), .rst(rst_b), .mem_req(req_b), .mem_addr(addr_b), .mem_ack(ack_b),
    .mem_rdata(rdata_b), .instr_valid(valid_b), .instr_ready(ready_b),
    .instr(instr_b), .instr_len(len_b), .instr_pc(pc_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b)
  );

  initial forever #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[10:1]];
  assign rdata_b   = (addr_b == 32'hFFFF_FFFE) ? 16'h4ABC :
                     (addr_b == 32'h0000_0000) ? 16'h1111 : 16'hDEAD;

  function automatic int unsigned len_at(input logic [31:0] pc);
    logic [15:0] hw;
    hw = mem[pc[10:1]];
    case (hw[15:14])
      2'd0:    return 1;
      2'd3:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [47:0] exp_instr(input logic [31:0] pc);
    logic [31:0] a1, a2;
    logic [15:0] h1, h2;
    int unsigned l;
    a1 = pc + 32'd2;
    a2 = pc + 32'd4;
    l  = len_at(pc);
    h1 = (l > 1) ? mem[a1[10:1]] : 16'h0000;
    h2 = (l > 2) ? mem[a2[10:1]] : 16'h0000;
    return {mem[pc[10:1]], h1, h2};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pc of the instruction in flight, halfwords acked so far, holding flag.
  bit          m_started = 1'b0;
  bit          m_hold    = 1'b0;
  logic [31:0] m_pc      = 32'd0;
  int unsigned m_cnt     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1'b0; m_pc <= 32'd0; m_cnt <= 0; m_hold <= 1'b0;
    end else if (redirect_valid) begin
      m_started <= 1'b1; m_pc <= redirect_pc & ~32'd1; m_cnt <= 0; m_hold <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (m_hold) begin
      if (instr_ready) begin
        m_pc <= m_pc + 32'(2 * len_at(m_pc)); m_cnt <= 0; m_hold <= 1'b0;
      end
    end else if (mem_ack) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == len_at(m_pc)) m_hold <= 1'b1;
    end
  end

  always @(negedge clk) begin
    n_vec++;
    if (instr_valid && instr_ready) n_hs++;
    chk("mem_req", 48'(mem_req), 48'(m_started && !m_hold));
    chk("instr_valid", 48'(instr_valid), 48'(m_started && m_hold));
    if (m_started && !m_hold) chk("mem_addr", 48'(mem_addr), 48'(m_pc + 32'(2 * m_cnt)));
    if (m_started && m_hold) begin
      chk("instr", instr, exp_instr(m_pc));
      chk("instr_len", 48'(instr_len), 48'(len_at(m_pc)));
      chk("instr_pc", 48'(instr_pc), 48'(m_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0123; mem[1] = 16'hC005; mem[2] = 16'h1234; mem[3] = 16'h5678;
    mem[4] = 16'hC111; mem[5] = 16'h2222; mem[6] = 16'h3333;
    mem[7] = 16'hC777; mem[8] = 16'h8888; mem[9] = 16'h9999;
    mem[10'h80] = 16'h0042; mem[10'h20] = 16'h0040;

    rst = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    rst_b = 1'b1; ack_b = 1'b0; ready_b = 1'b0; rv_b = 1'b0; rpc_b = 32'd0;
    step(); step();
    chk("rst_req", 48'(mem_req), 48'd0);
    chk("rst_addr", 48'(mem_addr), 48'd0);
    chk("rst_valid", 48'(instr_valid), 48'd0);
    chk("rst_instr", instr, 48'd0);
    chk("rst_len", 48'(instr_len), 48'd0);
    chk("rst_pc", 48'(instr_pc), 48'd0);
    rst = 1'b0; rst_b = 1'b0;
    step();
    chk("first_req", 48'(mem_req), 48'd1);
    chk("first_addr", 48'(mem_addr), 48'd0);
    step();
    chk("g0_instr", instr, 48'h0123_0000_0000);
    chk("g0_len", 48'(instr_len), 48'd1);
    chk("g0_pc", 48'(instr_pc), 48'd0);
    step(); chk("g3_addr0", 48'(mem_addr), 48'd2);
    step(); chk("g3_addr1", 48'(mem_addr), 48'd4);
    step(); chk("g3_addr2", 48'(mem_addr), 48'd6);
    step();
    chk("g3_instr", instr, 48'hC005_1234_5678);
    chk("g3_len", 48'(instr_len), 48'd3);
    chk("g3_pc", 48'(instr_pc), 48'd2);
    step(); chk("next_addr8", 48'(mem_addr), 48'd8);
    instr_ready = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 48'(instr_valid), 48'd1);
      chk("stall_instr", instr, 48'hC111_2222_3333);
      chk("stall_pc", 48'(instr_pc), 48'd8);
      chk("stall_req", 48'(mem_req), 48'd0);
      step();
    end
    instr_ready = 1'b1;
    step(); chk("addr14", 48'(mem_addr), 48'd14);
    step(); chk("addr16", 48'(mem_addr), 48'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
    step();
    redirect_valid = 1'b0;
    chk("redir_addr", 48'(mem_addr), 48'h100);
    chk("redir_valid", 48'(instr_valid), 48'd0);
    step();
    chk("redir_instr", instr, 48'h0042_0000_0000);
    chk("redir_pc", 48'(instr_pc), 48'h100);
    hs0 = n_hs;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    chk("hsr_addr", 48'(mem_addr), 48'h40);
    chk("hsr_valid", 48'(instr_valid), 48'd0);
    chk("hsr_count", 48'(n_hs - hs0), 48'd1);
    step(); chk("hsr_pc", 48'(instr_pc), 48'h40);
    step(); chk("hsr_count2", 48'(n_hs - hs0), 48'd2);

    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 399) == 0);
      mem_ack        = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom & 32'h0000_07FF;
      step();
    end
    rst = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk("wrap_req0", 48'(req_b), 48'd1);
      chk("wrap_addr0", 48'(addr_b), 48'hFFFF_FFFE);
      step();
    end
    ack_b = 1'b1; step(); ack_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_addr1", 48'(addr_b), 48'd0);
      chk("wrap_nvalid", 48'(valid_b), 48'd0);
      step();
    end
    ack_b = 1'b1; step(); ack_b = 1'b0;
    chk("wrap_valid", 48'(valid_b), 48'd1);
    chk("wrap_instr", instr_b, 48'h4ABC_1111_0000);
    chk("wrap_len", 48'(len_b), 48'd2);
    chk("wrap_pc", 48'(pc_b), 48'hFFFF_FFFE);
    step();
    chk("wrap_hold", instr_b, 48'h4ABC_1111_0000);
    ready_b = 1'b1;
    step();
    chk("wrap_next", 48'(addr_b), 48'd2);
    chk("wrap_nreq", 48'(req_b), 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
